y_writeback: RTL and testbench
==============================

Name: y_writeback

Overview:
- Drains the N x N result tile out of systolic_array and writes it into the Y scratchpad (sram_0rw1r1w_32_64_freepdk45, write port0, active-low CSB0).
- Sits directly downstream of the array inside the top-level datapath.
- Owns the array's y_index select, walking the tile row by row and streaming one 32-bit word per cycle into SPAD_Y.
- Leaves SPAD_Y port1 free for host readback.

Parameters:
- N, 4, systolic array dimension; tile is N*N words
- AW, 6, SPAD_Y address width (64 words)
- DW, 32, data word width
- ROW_STRIDE, N, address increment between consecutive result rows in SPAD_Y

Ports:
- clk  input  1  clock; all state on rising edge
- n_rst  input  1  asynchronous, active-low reset
- start_i  input  1  one-cycle pulse requesting writeback of the current tile
- base_addr_y  input  AW  SPAD_Y address of element (0,0); sampled on accepted start_i
- sa_stall_i  input  1  array stall/compute-in-progress; high means results not yet valid
- y_index_o  output  $clog2(N)  row select to systolic_array y_index
- y_row_i  input  N*DW (packed [N-1:0][DW-1:0])  row data from systolic_array y_out for y_index_o
- spad_y_csb0_o  output  1  SPAD_Y port0 chip select, active-low
- spad_y_addr0_o  output  AW  SPAD_Y port0 address
- spad_y_din0_o  output  DW  SPAD_Y port0 write data
- busy_o  output  1  high from accepted start until done
- done_o  output  1  one-cycle pulse after last word written

Behaviour:
- Reset (async, n_rst low): state IDLE; y_index_o=0; spad_y_csb0_o=1; spad_y_addr0_o=0; spad_y_din0_o=0; busy_o=0; done_o=0; row/col counters=0.
- Reset mid-transfer aborts immediately. No partial-completion signalling. CSB0 must be high in the same cycle reset asserts.
- All outputs are registered. No combinational path from inputs to outputs.
- IDLE:
  - start_i=1 -> WAIT_SA. Latch base_addr_y; row=0; busy_o<=1.
  - start_i while busy_o=1 is ignored.
- WAIT_SA: hold while sa_stall_i=1. On sa_stall_i=0 -> SEL_ROW with y_index_o<=row.
- SEL_ROW: exactly one cycle so y_row_i settles; CSB0 stays high. Then -> WRITE with col=0.
- WRITE: each cycle register:
  - spad_y_csb0_o<=0
  - spad_y_addr0_o<=base+row*ROW_STRIDE+col
  - spad_y_din0_o<=y_row_i[col]
- WRITE exit:
  - col==N-1 and row<N-1 -> SEL_ROW; row++, y_index_o<=row+1.
  - col==N-1 and row==N-1 -> DONE.
  - otherwise col++.
- DONE: spad_y_csb0_o<=1; done_o<=1 for one cycle; busy_o<=0; -> IDLE. A start_i in DONE is ignored.
- Address arithmetic is modulo 2^AW: base near 63 wraps to 0. There is no overflow flag.
- CSB0 is high in every state except WRITE. Addr/din hold their last values while CSB0 is high.
- sa_stall_i rising after WAIT_SA is ignored. The upstream loader does not restart the array while busy_o=1.
- Timing, stall already low: start at edge 0 -> first SRAM write sampled at edge 4. For N=4: 16 writes, done_o high in cycle 22, busy_o low from edge 23.

Optional Feature:
- Macro: Y_WRITEBACK_RELU_EN.
- Defined: spad_y_din0_o <= (y_row_i[col] signed negative) ? 0 : y_row_i[col]. This is a ReLU on 32-bit two's complement, applied in the same registered stage with no added latency.
- Undefined: data passed unmodified. Port list identical in both builds.

Decomposition:
- Shared package systolic_array_pkg gains:
  - wb_state_t enum {WB_IDLE, WB_WAIT_SA, WB_SEL_ROW, WB_WRITE, WB_DONE}
  - word_t (DW=32) reuse
- No sub-module required. The optional ReLU is a small function in the package (relu_word), not a module.

Test Plan:
- Tile 1..16, stall low, base=0, N=4, start pulse -> SPAD_Y[0..15]=1..16 row-major; done_o high in cycle 22; exactly 16 CSB0-low cycles.
- sa_stall_i held high 10 cycles after start -> no CSB0 low until stall drops; first write 4 cycles after stall falls; data correct.
- base_addr_y=60, ROW_STRIDE=4 -> words land at 60..63 then wrap 0..11; SPAD_Y[0] = element (1,0).
- Second start_i at cycle 8 of a transfer -> ignored; single done_o pulse; 16 writes total.
- n_rst low at cycle 10 -> CSB0=1, busy_o=0 immediately. Fresh start after release completes a full 16-word writeback.
- Y_WRITEBACK_RELU_EN build, tile containing 0xFFFFFFF6 (-10) and 7 -> SPAD_Y holds 0 and 7. Non-ReLU build holds 0xFFFFFFF6 and 7.

Source files
------------

// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic array datapath: word type, writeback FSM states
// and the ReLU helper used by y_writeback when Y_WRITEBACK_RELU_EN is defined.
package systolic_array_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        WB_IDLE,
        WB_WAIT_SA,
        WB_SEL_ROW,
        WB_WRITE,
        WB_DONE
    } wb_state_t;

    // Clamp negative two's-complement words to zero.
    function automatic word_t relu_word(input word_t w);
        return w[WORD_W-1] ? '0 : w;
    endfunction

endpackage

// File: rtl/y_writeback.sv
// Streams the N x N result tile from the systolic array into SPAD_Y port0,
// one word per cycle, row-major. Define Y_WRITEBACK_RELU_EN to clamp negatives.
module y_writeback
    import systolic_array_pkg::*;
#(
    parameter int N          = 4,
    parameter int AW         = 6,
    parameter int DW         = 32,
    parameter int ROW_STRIDE = N
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       start_i,
    input  logic [AW-1:0]              base_addr_y,
    input  logic                       sa_stall_i,
    output logic [$clog2(N)-1:0]       y_index_o,
    input  logic [N-1:0][DW-1:0]       y_row_i,
    output logic                       spad_y_csb0_o,
    output logic [AW-1:0]              spad_y_addr0_o,
    output logic [DW-1:0]              spad_y_din0_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int RW = $clog2(N);
    localparam logic [RW-1:0] LAST = RW'(N - 1);

    wb_state_t      state_q, state_d;
    logic [RW-1:0]  row_q, row_d, col_q, col_d, yidx_q, yidx_d;
    logic [AW-1:0]  base_q, base_d, addr_q, addr_d;
    logic [DW-1:0]  din_q, din_d;
    logic           csb_q, csb_d, busy_q, busy_d, done_q, done_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= WB_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            yidx_q  <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            csb_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            yidx_q  <= yidx_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            csb_q   <= csb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        yidx_d  = yidx_q;
        base_d  = base_q;
        addr_d  = addr_q;
        din_d   = din_q;
        csb_d   = 1'b1;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            WB_IDLE: begin
                // busy stays up through the done cycle so a start there is dropped
                if (done_q) busy_d = 1'b0;
                if (start_i && !busy_q) begin
                    state_d = WB_WAIT_SA;
                    base_d  = base_addr_y;
                    row_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            WB_WAIT_SA: begin
                if (!sa_stall_i) begin
                    state_d = WB_SEL_ROW;
                    yidx_d  = row_q;
                end
            end
            WB_SEL_ROW: begin
                state_d = WB_WRITE;
                col_d   = '0;
            end
            WB_WRITE: begin
                csb_d  = 1'b0;
                addr_d = base_q + AW'(row_q) * AW'(ROW_STRIDE) + AW'(col_q);
`ifdef Y_WRITEBACK_RELU_EN
                din_d  = relu_word(y_row_i[col_q]);
`else
                din_d  = y_row_i[col_q];
`endif
                if (col_q == LAST) begin
                    if (row_q == LAST) begin
                        state_d = WB_DONE;
                    end else begin
                        state_d = WB_SEL_ROW;
                        row_d   = row_q + 1'b1;
                        yidx_d  = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            WB_DONE: begin
                done_d  = 1'b1;
                state_d = WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    assign y_index_o      = yidx_q;
    assign spad_y_csb0_o  = csb_q;
    assign spad_y_addr0_o = addr_q;
    assign spad_y_din0_o  = din_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_y_writeback.sv
// Directed bench for y_writeback with a behavioural SPAD_Y port0 model.
module tb_y_writeback;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start_i = 1'b0;
    logic [5:0]        base_addr_y = '0;
    logic              sa_stall_i = 1'b0;
    logic [1:0]        y_index_o;
    logic [3:0][31:0]  y_row_i;
    logic              spad_y_csb0_o;
    logic [5:0]        spad_y_addr0_o;
    logic [31:0]       spad_y_din0_o;
    logic              busy_o;
    logic              done_o;

    logic [31:0] tile [4][4];
    logic [31:0] mem  [64];
    int cyc = 0, nwr = 0, ndone = 0, first_wr = -1, start_cyc = 0;
    int total = 0, bad = 0;

    y_writeback dut (
        .clk(clk), .n_rst(n_rst), .start_i(start_i), .base_addr_y(base_addr_y),
        .sa_stall_i(sa_stall_i), .y_index_o(y_index_o), .y_row_i(y_row_i),
        .spad_y_csb0_o(spad_y_csb0_o), .spad_y_addr0_o(spad_y_addr0_o),
        .spad_y_din0_o(spad_y_din0_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    always_comb
        for (int c = 0; c < 4; c++) y_row_i[c] = tile[y_index_o][c];

    // SRAM port0 model plus event counters
    always @(posedge clk) begin
        if (!spad_y_csb0_o) begin
            mem[spad_y_addr0_o] = spad_y_din0_o;
            nwr = nwr + 1;
            if (first_wr < 0) first_wr = cyc;
        end
        if (done_o) ndone = ndone + 1;
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] off);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) tile[r][c] = off + 32'(r * 4 + c + 1);
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask

    task automatic kick(input logic [5:0] b);
        start_i = 1'b1;
        base_addr_y = b;
        nwr = 0;
        ndone = 0;
        first_wr = -1;
        @(posedge clk);
        #1;
        start_cyc = cyc - 1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int rel);
        rel = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done_o) begin
                rel = cyc - 1 - start_cyc;
                break;
            end
        end
        chk("done_seen", 32'(rel >= 0), 32'd1);
    endtask

    task automatic chk_tile(input string tag, input logic [5:0] b);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chk(tag, mem[6'(b + 6'(r * 4 + c))], tile[r][c]);
    endtask

    initial begin
        int rel;
        fill(32'd0);
        tick();
        tick();
        chk("rst_csb", 32'(spad_y_csb0_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_addr", 32'(spad_y_addr0_o), 32'd0);
        chk("rst_din", spad_y_din0_o, 32'd0);
        chk("rst_yidx", 32'(y_index_o), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        // basic tile, stall low, base 0
        kick(6'd0);
        chk("t1_busy", 32'(busy_o), 32'd1);
        wait_done(rel);
        chk("t1_done_cyc", 32'(rel), 32'd22);
        chk("t1_busy_in_done", 32'(busy_o), 32'd1);
        chk("t1_first_wr", 32'(first_wr - start_cyc), 32'd4);
        chk("t1_yidx_last", 32'(y_index_o), 32'd3);
        tick();
        chk("t1_busy_low", 32'(busy_o), 32'd0);
        chk("t1_done_low", 32'(done_o), 32'd0);
        chk("t1_nwr", 32'(nwr), 32'd16);
        chk("t1_ndone", 32'(ndone), 32'd1);
        chk_tile("t1_mem", 6'd0);

        // stall held for 10 cycles
        fill(32'h100);
        sa_stall_i = 1'b1;
        kick(6'd16);
        for (int i = 0; i < 10; i++) tick();
        chk("t2_no_wr", 32'(nwr), 32'd0);
        chk("t2_csb", 32'(spad_y_csb0_o), 32'd1);
        sa_stall_i = 1'b0;
        start_cyc = cyc - 1;
        wait_done(rel);
        chk("t2_first_wr", 32'(first_wr - start_cyc), 32'd4);
        chk("t2_nwr", 32'(nwr), 32'd16);
        chk_tile("t2_mem", 6'd16);
        tick();

        // address wrap from base 60
        fill(32'hA0);
        kick(6'd60);
        wait_done(rel);
        tick();
        chk("t3_nwr", 32'(nwr), 32'd16);
        chk("t3_mem60", mem[60], 32'hA1);
        chk("t3_mem0", mem[0], 32'hA5);
        chk("t3_mem11", mem[11], 32'hB0);
        chk_tile("t3_mem", 6'd60);

        // second start mid-transfer is dropped
        fill(32'h200);
        kick(6'd8);
        for (int i = 0; i < 7; i++) tick();
        start_i = 1'b1;
        base_addr_y = 6'd40;
        tick();
        start_i = 1'b0;
        wait_done(rel);
        for (int i = 0; i < 30; i++) tick();
        chk("t4_nwr", 32'(nwr), 32'd16);
        chk("t4_ndone", 32'(ndone), 32'd1);
        chk("t4_busy", 32'(busy_o), 32'd0);
        chk_tile("t4_mem", 6'd8);

        // reset mid-transfer, then fresh run
        fill(32'h300);
        kick(6'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("t5_pre_csb", 32'(spad_y_csb0_o), 32'd0);
        n_rst = 1'b0;
        #1;
        chk("t5_rst_csb", 32'(spad_y_csb0_o), 32'd1);
        chk("t5_rst_busy", 32'(busy_o), 32'd0);
        chk("t5_rst_yidx", 32'(y_index_o), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) mem[i] = '0;
        kick(6'd0);
        wait_done(rel);
        chk("t5_done_cyc", 32'(rel), 32'd22);
        chk("t5_nwr", 32'(nwr), 32'd16);
        chk_tile("t5_mem", 6'd0);
        tick();

        // negative word handling
        fill(32'd0);
        tile[0][1] = 32'hFFFF_FFF6;
        tile[2][3] = 32'd7;
        kick(6'd32);
        wait_done(rel);
        tick();
`ifdef Y_WRITEBACK_RELU_EN
        chk("t6_neg", mem[33], 32'd0);
`else
        chk("t6_neg", mem[33], 32'hFFFF_FFF6);
`endif
        chk("t6_pos", mem[43], 32'd7);
        chk("t6_other", mem[32], 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
